ultrasonico_scheduler: RTL

- Fires N ultrasonic rangers one at a time in round-robin order, so that one sensor's burst is never taken as another sensor's echo.
- For each channel it generates the trigger pulse, measures echo width in microseconds, and applies a per-channel obstacle threshold to update a flag.
- It also publishes each measurement with a valid strobe.
- It sits between the sensor pins and the motion/lighting logic and replaces per-sensor free-running controllers.

---
 rtl/ultrasonico_pkg.sv | 27 ++
 rtl/ultrasonico_scheduler_if.sv | 28 ++
 rtl/us_tick_gen.sv | 27 ++
 rtl/ultrasonico_scheduler.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ultrasonico_pkg.sv
// Shared types and defaults for the round-robin ultrasonic ranger scheduler.
package ultrasonico_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TRIGGER,
      ESPERANDO,
      SENSANDO,
      GUARD
   } sched_state_t;

   localparam int DEF_N_SENSORS  = 4;
   localparam int DEF_CLK_PER_US = 50;
   localparam int DEF_TRIG_US    = 10;
   localparam int DEF_TIMEOUT_US = 30000;
   localparam int DEF_GUARD_US   = 10000;
   localparam int DEF_THRESH_US  = 2500;

   localparam int                DIST_W   = 16;
   localparam logic [DIST_W-1:0] DIST_SAT = 16'hFFFF;

   // Width counters stick at the saturate value instead of wrapping to zero.
   function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] v);
      return (v == DIST_SAT) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/ultrasonico_scheduler_if.sv
// Sensor pins and measurement results of the ultrasonic scheduler, grouped as one bus.
interface ultrasonico_scheduler_if
   import ultrasonico_pkg::*;
#(
   parameter int N_SENSORS = DEF_N_SENSORS
);
   localparam int CH_W = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;

   logic                  enable;
   logic [N_SENSORS-1:0]  eco;
   logic [N_SENSORS-1:0]  trigger;
   logic [N_SENSORS-1:0]  interferencia;
   logic [DIST_W-1:0]     dist_us;
   logic [CH_W-1:0]       dist_ch;
   logic                  dist_valid;
   logic                  timeout_err;

   modport master (
      input  enable, eco,
      output trigger, interferencia, dist_us, dist_ch, dist_valid, timeout_err
   );

   modport slave (
      output enable, eco,
      input  trigger, interferencia, dist_us, dist_ch, dist_valid, timeout_err
   );

endinterface

// File: rtl/us_tick_gen.sv
// Microsecond tick generator: one-clk pulse every CLK_PER_US clocks, restartable via clear.
module us_tick_gen #(
   parameter int CLK_PER_US = 50
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);
   localparam int            CW   = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
   localparam logic [CW-1:0] TERM = CW'(CLK_PER_US - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (cnt == TERM) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == TERM);

endmodule

// File: rtl/ultrasonico_scheduler.sv
// Round-robin ultrasonic ranger scheduler: trigger, echo timing, obstacle flags, result strobes.
// Define ULTRASONICO_ECO_SYNC_EN to add a 2-flop synchronizer on every eco input.
module ultrasonico_scheduler
   import ultrasonico_pkg::*;
#(
   parameter int N_SENSORS  = DEF_N_SENSORS,
   parameter int CLK_PER_US = DEF_CLK_PER_US,
   parameter int TRIG_US    = DEF_TRIG_US,
   parameter int TIMEOUT_US = DEF_TIMEOUT_US,
   parameter int GUARD_US   = DEF_GUARD_US,
   parameter int THRESH_US  = DEF_THRESH_US
) (
   input logic                     clk,
   input logic                     reset,
   ultrasonico_scheduler_if.master bus
);
   localparam int                CH_W      = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
   localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(N_SENSORS - 1);
   localparam logic [DIST_W-1:0] TRIG_L    = DIST_W'(TRIG_US);
   localparam logic [DIST_W-1:0] TIMEOUT_L = DIST_W'(TIMEOUT_US);
   localparam logic [DIST_W-1:0] GUARD_L   = DIST_W'(GUARD_US);
   localparam logic [DIST_W-1:0] THRESH_L  = DIST_W'(THRESH_US);

   sched_state_t          state, state_next;
   logic [CH_W-1:0]       ch, ch_next;
   logic [DIST_W-1:0]     timer, timer_next, width, width_next;
   logic                  tick, tick_clear, publish, pub_timeout, eco_ch;
   logic [N_SENSORS-1:0]  eco_s, trig_next, trigger_q, irf_q;
   logic [DIST_W-1:0]     dist_us_q;
   logic [CH_W-1:0]       dist_ch_q;
   logic                  dist_valid_q, timeout_err_q;

   us_tick_gen #(.CLK_PER_US(CLK_PER_US)) u_tick (
      .clk   (clk),
      .reset (reset),
      .clear (tick_clear),
      .tick  (tick)
   );

`ifdef ULTRASONICO_ECO_SYNC_EN
   logic [N_SENSORS-1:0] eco_meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         eco_meta <= '0;
         eco_s    <= '0;
      end else begin
         eco_meta <= bus.eco;
         eco_s    <= eco_meta;
      end
   end
`else
   assign eco_s = bus.eco;
`endif

   assign eco_ch = eco_s[ch];

   // Next-state logic; everything except the IDLE exit advances only on a tick.
   always_comb begin
      state_next  = state;
      ch_next     = ch;
      timer_next  = timer;
      width_next  = width;
      publish     = 1'b0;
      pub_timeout = 1'b0;
      tick_clear  = 1'b0;
      trig_next   = '0;
      case (state)
         IDLE: begin
            tick_clear = 1'b1;
            timer_next = '0;
            if (bus.enable) state_next = TRIGGER;
         end
         TRIGGER: if (tick) begin
            if (timer == TRIG_L - 1'b1) begin
               state_next = ESPERANDO;
               timer_next = '0;
            end else begin
               timer_next = timer + 1'b1;
            end
         end
         ESPERANDO: if (tick) begin
            if (eco_ch) begin
               state_next = SENSANDO;
               width_next = 16'd1;
               timer_next = '0;
            end else if (timer == TIMEOUT_L - 1'b1) begin
               state_next  = GUARD;
               pub_timeout = 1'b1;
               timer_next  = '0;
            end else begin
               timer_next = timer + 1'b1;
            end
         end
         SENSANDO: if (tick) begin
            if (!eco_ch) begin
               state_next = GUARD;
               publish    = 1'b1;
            end else if (sat_inc(width) >= TIMEOUT_L) begin
               state_next  = GUARD;
               pub_timeout = 1'b1;
            end else begin
               width_next = sat_inc(width);
            end
         end
         GUARD: if (tick) begin
            if (timer == GUARD_L - 1'b1) begin
               timer_next = '0;
               ch_next    = (ch == LAST_CH) ? '0 : ch + 1'b1;
               state_next = bus.enable ? TRIGGER : IDLE;
            end else begin
               timer_next = timer + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
      if (state_next == TRIGGER) trig_next[ch_next] = 1'b1;
   end

   // Trigger pins and results are registered so the sensor pins never glitch.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         ch            <= '0;
         timer         <= '0;
         width         <= '0;
         trigger_q     <= '0;
         irf_q         <= '0;
         dist_us_q     <= '0;
         dist_ch_q     <= '0;
         dist_valid_q  <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state         <= state_next;
         ch            <= ch_next;
         timer         <= timer_next;
         width         <= width_next;
         trigger_q     <= trig_next;
         dist_valid_q  <= publish | pub_timeout;
         timeout_err_q <= pub_timeout;
         if (publish) begin
            dist_us_q <= width;
            dist_ch_q <= ch;
            irf_q[ch] <= (width != '0) && (width < THRESH_L);
         end else if (pub_timeout) begin
            dist_us_q <= DIST_SAT;
            dist_ch_q <= ch;
            irf_q[ch] <= 1'b0;
         end
      end
   end

   assign bus.trigger       = trigger_q;
   assign bus.interferencia = irf_q;
   assign bus.dist_us       = dist_us_q;
   assign bus.dist_ch       = dist_ch_q;
   assign bus.dist_valid    = dist_valid_q;
   assign bus.timeout_err   = timeout_err_q;

endmodule
